// File: rtl/aes_spi_host.sv
// SPI mode-0 host for the AES slave: sends {plaintext, key_len, key}, waits a
// settle gap with cs high, then clocks a second frame to read the ciphertext.
module aes_spi_host #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  input  logic [7:0]   key_len,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] ciphertext,
  output logic         sclk,
  output logic         cs,
  output logic         mosi,
  input  logic         miso
);
  localparam int FRAME_BITS = 392;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_GAP, S_RX, S_FIN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [FRAME_BITS-1:0]   r_cap;
  logic [DIV_W-1:0]        r_div;
  logic [GAP_W-1:0]        r_gap;
  logic [BIT_W-1:0]        r_bit;
  logic                    r_tail;
  logic                    r_sclk;
  logic                    r_cs;
  logic                    r_mosi;
  logic                    r_done;
  logic                    r_err;
  logic [127:0]            r_ciphertext;

  logic w_key_ok;
  logic w_div_tick;
  logic w_gap_tick;
  logic w_last_bit;
  logic w_xfer_end;

  assign w_key_ok   = (key_len == 8'd16) || (key_len == 8'd24) || (key_len == 8'd32);
  assign w_div_tick = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_gap_tick = (r_gap == GAP_W'(GAP_CYCLES - 1));
  assign w_last_bit = (r_bit == BIT_W'(FRAME_BITS - 1));
  // r_tail marks the final half-period after the last falling edge, before cs rises.
  assign w_xfer_end = r_tail && w_div_tick;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start && w_key_ok) w_state_next = S_TX;
      S_TX:   if (w_xfer_end) w_state_next = S_GAP;
      S_GAP:  if (w_gap_tick) w_state_next = S_RX;
      S_RX:   if (w_xfer_end) w_state_next = S_FIN;
      S_FIN:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_cap        <= '0;
      r_div        <= '0;
      r_gap        <= '0;
      r_bit        <= '0;
      r_tail       <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs         <= 1'b1;
      r_mosi       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_ciphertext <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div  <= '0;
          r_gap  <= '0;
          r_bit  <= '0;
          r_tail <= 1'b0;
          r_sclk <= 1'b0;
          if (start) begin
            if (w_key_ok) begin
              r_shift <= {plaintext, key_len, key};
              r_cs    <= 1'b0;
              r_mosi  <= plaintext[127];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_TX, S_RX: begin
          if (w_div_tick) begin
            r_div <= '0;
            if (r_tail) begin
              r_tail <= 1'b0;
              r_cs   <= 1'b1;
              r_mosi <= 1'b0;
              r_gap  <= '0;
            end else if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_cap  <= {r_cap[FRAME_BITS-2:0], miso};
            end else begin
              r_sclk <= 1'b0;
              if (w_last_bit) begin
                r_bit  <= '0;
                r_tail <= 1'b1;
              end else begin
                r_bit   <= r_bit + BIT_W'(1);
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                r_mosi  <= (r_state == S_TX) ? r_shift[FRAME_BITS-2] : 1'b0;
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_GAP: begin
          r_sclk <= 1'b0;
          r_div  <= '0;
          if (w_gap_tick) begin
            r_gap  <= '0;
            r_cs   <= 1'b0;
            r_mosi <= 1'b0;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        S_FIN: begin
          r_ciphertext <= r_cap[FRAME_BITS-1 -: 128];
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done       = r_done;
  assign err        = r_err;
  assign ciphertext = r_ciphertext;
  assign sclk       = r_sclk;
  assign cs         = r_cs;
  assign mosi       = r_mosi;
endmodule

// File: tb/tb_aes_spi_host.sv
// Directed bench for aes_spi_host with a mode-0 SPI slave model that answers
// the FIPS-197 known-answer vectors and monitors the wire.
module tb_aes_spi_host;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] plaintext;
  logic [255:0] key;
  logic [7:0]   key_len;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] ciphertext;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso = 1'b0;

  aes_spi_host #(.CLK_DIV(4), .GAP_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .plaintext(plaintext), .key(key),
    .key_len(key_len), .busy(busy), .done(done), .err(err), .ciphertext(ciphertext),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave answers only a frame that exactly matches one of the known vectors.
  function automatic logic [127:0] slave_answer(input logic [391:0] f);
    if (f == {PT, 8'd16, K128}) return CT128;
    if (f == {PT, 8'd24, K192}) return CT192;
    if (f == {PT, 8'd32, K256}) return CT256;
    return 128'hbadbadbadbadbadbadbadbadbadbad00;
  endfunction

  // Passive monitor + slave; one process owns all of its state.
  logic [391:0] mon_sh  = '0;
  logic [391:0] out_sh  = '0;
  logic [391:0] tx_seen = '0;
  logic [391:0] rx_mosi = '0;
  logic [127:0] resp    = '0;
  logic         prev_cs = 1'b0;
  logic         prev_sclk = 1'b0;
  bit           in_win  = 1'b0;
  bit           phase   = 1'b0;
  int           rises = 0, tx_rises = 0, rx_rises = 0;
  int           tx_wins = 0, rx_wins = 0;
  int           t_rise = 0, gap_seen = 0;

  always @(posedge cs or negedge cs or posedge sclk or negedge sclk) begin
    if (cs !== prev_cs) begin
      if (cs === 1'b0) begin
        in_win = 1'b1;
        rises  = 0;
        mon_sh = '0;
        if (phase) begin
          gap_seen = cyc - t_rise;
          out_sh   = {resp, 264'h0};
        end else begin
          out_sh = '0;
        end
        miso = out_sh[391];
      end else if (in_win) begin
        in_win = 1'b0;
        if (!phase && rises == 392) begin
          phase    = 1'b1;
          tx_seen  = mon_sh;
          tx_rises = rises;
          t_rise   = cyc;
          resp     = slave_answer(mon_sh);
          tx_wins++;
        end else if (phase) begin
          phase    = 1'b0;
          rx_rises = rises;
          rx_mosi  = mon_sh;
          rx_wins++;
        end
      end
    end else if (sclk !== prev_sclk && in_win) begin
      if (sclk === 1'b1) begin
        mon_sh = {mon_sh[390:0], mosi};
        rises++;
      end else begin
        out_sh = {out_sh[390:0], 1'b0};
        miso   = out_sh[391];
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  task automatic run_enc(input string tag, input logic [255:0] k, input logic [7:0] kl,
                         input logic [127:0] exp_ct, input bit poke);
    int n;
    int d0, tw0, rw0;
    d0  = done_cnt;
    tw0 = tx_wins;
    rw0 = rx_wins;
    @(negedge clk);
    plaintext = PT; key = k; key_len = kl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check_eq($sformatf("%s_cs_c1", tag), 256'(cs), 256'(0));
    check_eq($sformatf("%s_busy_c1", tag), 256'(busy), 256'(1));
    check_eq($sformatf("%s_mosi_c1", tag), 256'(mosi), 256'(PT[127]));
    while (!done && n < 8000) begin
      @(negedge clk);
      n++;
      if (poke && n == 500) begin start = 1'b1; plaintext = '1; key_len = 8'd16; end
      if (poke && n == 501) start = 1'b0;
    end
    plaintext = PT;
    key_len   = kl;
    check_eq($sformatf("%s_done_cycle", tag), 256'(n), 256'(6298));
    check_eq($sformatf("%s_ct", tag), 256'(ciphertext), 256'(exp_ct));
    $display("txn %s key_len=%0d ciphertext=%h done_cycle=%0d", tag, kl, ciphertext, n);
    @(negedge clk);
    check_eq($sformatf("%s_done_pulse", tag), 256'(done), 256'(0));
    check_eq($sformatf("%s_busy_after", tag), 256'(busy), 256'(0));
    check_eq($sformatf("%s_done_count", tag), 256'(done_cnt - d0), 256'(1));
    check_eq($sformatf("%s_tx_windows", tag), 256'(tx_wins - tw0), 256'(1));
    check_eq($sformatf("%s_rx_windows", tag), 256'(rx_wins - rw0), 256'(1));
    check_eq($sformatf("%s_tx_rises", tag), 256'(tx_rises), 256'(392));
    check_eq($sformatf("%s_rx_rises", tag), 256'(rx_rises), 256'(392));
    check_eq($sformatf("%s_tx_pt_byte", tag), 256'(tx_seen[391:384]), 256'(PT[127:120]));
    check_eq($sformatf("%s_tx_keylen", tag), 256'(tx_seen[263:256]), 256'(kl));
    check_eq($sformatf("%s_tx_key", tag), tx_seen[255:0], k);
    check_eq($sformatf("%s_rx_mosi", tag), 256'(rx_mosi), 256'(0));
    check_eq($sformatf("%s_gap", tag), 256'(gap_seen), 256'(16));
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b1; start = 1'b0; plaintext = '0; key = '0; key_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_done", 256'(done), 256'(0));
    check_eq("rst_err", 256'(err), 256'(0));
    check_eq("rst_ct", 256'(ciphertext), 256'(0));
    check_eq("rst_sclk", 256'(sclk), 256'(0));
    check_eq("rst_cs", 256'(cs), 256'(1));
    check_eq("rst_mosi", 256'(mosi), 256'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal key length: err pulse only, no SPI activity.
    plaintext = PT; key = K128; key_len = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("bad_err_c1", 256'(err), 256'(1));
    check_eq("bad_cs_c1", 256'(cs), 256'(1));
    check_eq("bad_busy_c1", 256'(busy), 256'(0));
    @(negedge clk);
    check_eq("bad_err_c2", 256'(err), 256'(0));
    check_eq("bad_cs_c2", 256'(cs), 256'(1));
    check_eq("bad_busy_c2", 256'(busy), 256'(0));
    check_eq("bad_sclk_c2", 256'(sclk), 256'(0));

    run_enc("aes128", K128, 8'd16, CT128, 1'b0);
    run_enc("aes192", K192, 8'd24, CT192, 1'b1);
    run_enc("aes256", K256, 8'd32, CT256, 1'b0);

    // Abort mid-TX with reset at cycle 1000.
    @(negedge clk);
    plaintext = PT; key = K256; key_len = 8'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 1000) begin @(negedge clk); n++; end
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_cs", 256'(cs), 256'(1));
    check_eq("abort_sclk", 256'(sclk), 256'(0));
    check_eq("abort_mosi", 256'(mosi), 256'(0));
    check_eq("abort_busy", 256'(busy), 256'(0));
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("abort_no_done", 256'(done_cnt - d0), 256'(0));
    $display("txn abort reset at cycle %0d", n);

    run_enc("aes256_again", K256, 8'd32, CT256, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
